uart_tx: RTL and testbench

UART transmitter serialising bytes into 8N1 frames (8 data bits, no parity, configurable stop bits) on a single line `tx`. It is the transmit counterpart of the UART receiver, runs in the same `clk` domain and uses the same `CLK_Hz`/`BITRATE_bps` parameterisation, so both ends agree on bit timing. Bytes enter through a valid/ready handshake into a one-byte holding register, so a producer can queue the next byte while the current frame is on the line.

---
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register in front of the shift register.
// Bit timing is an integer clocks-per-bit count derived from CLK_Hz / BITRATE_bps.
module uart_tx #(
    parameter real CLK_Hz      = 66_000_000.0,
    parameter real BITRATE_bps = 9_600.0,
    parameter int  STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = int'(CLK_Hz / BITRATE_bps);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST  = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             bit_end;

    // Outputs are registered, so tx/busy/ready are computed from the state being entered.
    always_comb begin
        accept      = data_valid && ready_q;
        bit_end     = (cnt_q == CNT_LAST);

        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;

        // An accept needs an empty holding register, so it never collides with a transfer out of it.
        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = START;
                    tx_d        = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        // A queued byte starts on the very next edge, leaving no idle gap.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            state_d     = START;
                            tx_d        = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = !hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            stop_idx_q  <= 1'b0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign data_ready = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a one-stop-bit and a two-stop-bit instance share clock and reset;
// accepted bytes go into per-instance queues and a line monitor decodes and checks every frame.
module tb_uart_tx;

    localparam real CLK_HZ   = 16.0;
    localparam real BIT_BPS  = 1.0;
    localparam int  BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] expQ0[$];
    logic [7:0] expQ1[$];

    int busyRun0 = 0, lastBusy0 = 0, readyLow0 = 0, lastReadyLow0 = 0;
    int busyRun1 = 0, lastBusy1 = 0, readyLow1 = 0, lastReadyLow1 = 0;

    uart_tx #(.CLK_Hz(CLK_HZ), .BITRATE_bps(BIT_BPS), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data0),
        .data_valid (valid0),
        .data_ready (ready0),
        .tx         (tx0),
        .busy       (busy0)
    );

    uart_tx #(.CLK_Hz(CLK_HZ), .BITRATE_bps(BIT_BPS), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .data       (data1),
        .data_valid (valid1),
        .data_ready (ready1),
        .tx         (tx1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    // Track run lengths of busy-high and ready-low so whole-frame timing can be checked afterwards.
    always @(negedge clk) begin
        if (busy0 === 1'b1) busyRun0++;
        else if (busyRun0 != 0) begin lastBusy0 = busyRun0; busyRun0 = 0; end
        if (busy1 === 1'b1) busyRun1++;
        else if (busyRun1 != 0) begin lastBusy1 = busyRun1; busyRun1 = 0; end
        if (ready0 === 1'b0) readyLow0++;
        else if (readyLow0 != 0) begin lastReadyLow0 = readyLow0; readyLow0 = 0; end
        if (ready1 === 1'b0) readyLow1++;
        else if (readyLow1 != 0) begin lastReadyLow1 = readyLow1; readyLow1 = 0; end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic lineTx(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction

    function automatic logic lineReady(input int sel);
        return (sel == 0) ? ready0 : ready1;
    endfunction

    function automatic logic lineBusy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic int expSize(input int sel);
        return (sel == 0) ? expQ0.size() : expQ1.size();
    endfunction

    function automatic logic [7:0] popExp(input int sel);
        return (sel == 0) ? expQ0.pop_front() : expQ1.pop_front();
    endfunction

    task automatic pushExp(input int sel, input logic [7:0] b);
        if (sel == 0) expQ0.push_back(b);
        else          expQ1.push_back(b);
    endtask

    task automatic driveInput(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin valid0 = v; data0 = b; end
        else          begin valid1 = v; data1 = b; end
    endtask

    // Offers a byte and returns just after the edge that accepts it.
    task automatic applyStimulus(input int sel, input logic [7:0] b);
        int   n;
        logic r;
        n = 0;
        r = 1'b0;
        @(posedge clk); #1;
        driveInput(sel, 1'b1, b);
        while (!r && n < 2000) begin
            @(negedge clk);
            r = (lineReady(sel) === 1'b1);
            @(posedge clk);
            n++;
        end
        checkOutput($sformatf("accept dut%0d", sel), r, 1'b1);
        if (r) pushExp(sel, b);
        #1 driveInput(sel, 1'b0, 8'h00);
    endtask

    task automatic waitIdle(input int sel);
        int n;
        n = 0;
        @(negedge clk);
        while ((lineBusy(sel) !== 1'b0 || expSize(sel) != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("idle reached dut%0d", sel), (n < 5000), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: checks every cycle of a frame against the ideal waveform and decodes the byte mid-bit.
    task automatic monitorFrames(input int sel);
        int         spb, nCyc, bad, bitNo;
        logic [7:0] expByte, gotByte;
        logic       expLvl, lvl;
        bit         aborted, hasExp;
        spb  = (sel == 0) ? 1 : 2;
        nCyc = (9 + spb) * BIT_CLKS;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || lineTx(sel) !== 1'b0) continue;
            hasExp = (expSize(sel) > 0);
            checkOutput($sformatf("frame expected dut%0d", sel), hasExp, 1'b1);
            expByte = hasExp ? popExp(sel) : 8'h00;
            gotByte = 8'h00;
            bad     = 0;
            aborted = 0;
            for (int c = 0; c < nCyc; c++) begin
                if (c > 0) @(negedge clk);
                if (rst !== 1'b0) begin
                    aborted = 1;
                    break;
                end
                bitNo = c / BIT_CLKS;
                if (bitNo == 0)      expLvl = 1'b0;
                else if (bitNo <= 8) expLvl = expByte[bitNo-1];
                else                 expLvl = 1'b1;
                lvl = lineTx(sel);
                if (lvl !== expLvl) bad++;
                if (bitNo >= 1 && bitNo <= 8 && (c % BIT_CLKS) == BIT_CLKS / 2) gotByte[bitNo-1] = lvl;
            end
            if (!aborted) begin
                checkOutput($sformatf("rx byte dut%0d", sel), gotByte, expByte);
                checkOutput($sformatf("waveform bad cycles dut%0d", sel), bad, 0);
            end
        end
    endtask

    initial monitorFrames(0);
    initial monitorFrames(1);

    logic [7:0] pattern [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        int         cnt, accepts;
        logic [7:0] curByte;
        rst    = 1'b1;
        valid0 = 1'b0; data0 = 8'h00;
        valid1 = 1'b0; data1 = 8'h00;

        // Reset and quiet idle line.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset tx", tx0, 1'b1);
        checkOutput("reset ready", ready0, 1'b1);
        checkOutput("reset busy", busy0, 1'b0);
        checkOutput("reset tx dut2", tx1, 1'b1);
        checkOutput("reset ready dut2", ready1, 1'b1);
        checkOutput("reset busy dut2", busy1, 1'b0);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) cnt++;
        end
        checkOutput("idle stable", cnt, 0);

        // Single byte with start latency.
        applyStimulus(0, 8'hA5);
        @(negedge clk);
        checkOutput("k tx", tx0, 1'b1);
        checkOutput("k busy", busy0, 1'b0);
        checkOutput("k ready", ready0, 1'b0);
        @(negedge clk);
        checkOutput("k+1 tx", tx0, 1'b0);
        checkOutput("k+1 busy", busy0, 1'b1);
        checkOutput("k+1 ready", ready0, 1'b1);
        waitIdle(0);
        checkOutput("single busy len", lastBusy0, 160);
        checkOutput("single ready low", lastReadyLow0, 1);

        // Back-to-back frames.
        applyStimulus(0, 8'h00);
        applyStimulus(0, 8'hFF);
        waitIdle(0);
        checkOutput("b2b busy len", lastBusy0, 320);
        checkOutput("b2b ready low", lastReadyLow0, 159);

        // Hold protection: valid stays high while data changes.
        accepts = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            curByte = pattern[(i / 40) % 3];
            valid0  = 1'b1;
            data0   = curByte;
            @(negedge clk);
            if (ready0 === 1'b1) begin
                pushExp(0, curByte);
                accepts++;
            end
        end
        @(posedge clk); #1 valid0 = 1'b0;
        checkOutput("hold accepts", accepts, 4);
        waitIdle(0);
        checkOutput("hold busy len", lastBusy0, 640);

        // Reset during data bit 3 with a byte queued.
        applyStimulus(0, 8'h5A);
        applyStimulus(0, 8'hC3);
        repeat (68) @(posedge clk);
        #1 rst = 1'b1;
        expQ0.delete();
        expQ1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset tx", tx0, 1'b1);
        checkOutput("midreset busy", busy0, 1'b0);
        checkOutput("midreset ready", ready0, 1'b1);
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) cnt++;
        end
        checkOutput("queued byte dropped", cnt, 0);

        // Two stop bits, back-to-back.
        applyStimulus(1, 8'h3C);
        applyStimulus(1, 8'h81);
        waitIdle(1);
        checkOutput("2stop busy len", lastBusy1, 352);
        checkOutput("2stop ready low", lastReadyLow1, 175);

        checkOutput("scoreboard empty dut0", expQ0.size(), 0);
        checkOutput("scoreboard empty dut1", expQ1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
